// File: rtl/regfile_sb.sv
// regfile_sb: 32x32 general-purpose register file with a per-register issue scoreboard.
// Inputs are the writeback port (we/waddr/wdata), the issue port (iss_we/iss_addr) and two
// read ports (reN/raddrN). Outputs are the combinational read data (rdataN) and the busy
// flags (busyN). Defining REGFILE_BYPASS_EN forwards same-cycle writeback data to the readers.
module regfile_sb #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic              re1,
    input  logic [ADDR_W-1:0] raddr1,
    output logic [DATA_W-1:0] rdata1,
    input  logic              re2,
    input  logic [ADDR_W-1:0] raddr2,
    output logic [DATA_W-1:0] rdata2,
    input  logic              iss_we,
    input  logic [ADDR_W-1:0] iss_addr,
    output logic              busy1,
    output logic              busy2
);

    logic [DATA_W-1:0] regs [NREG];
    logic [NREG-1:0]   busy;
    logic              hit1;
    logic              hit2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else begin
            if (we && waddr != '0) begin
                regs[waddr] <= wdata;
            end
            busy[0] <= 1'b0;
            // A new issue outranks a retiring write to the same register.
            for (int i = 1; i < NREG; i++) begin
                if (iss_we && iss_addr == ADDR_W'(i)) begin
                    busy[i] <= 1'b1;
                end else if (we && waddr == ADDR_W'(i)) begin
                    busy[i] <= 1'b0;
                end
            end
        end
    end

`ifdef REGFILE_BYPASS_EN
    assign hit1 = we && re1 && raddr1 != '0 && waddr == raddr1;
    assign hit2 = we && re2 && raddr2 != '0 && waddr == raddr2;
`else
    assign hit1 = 1'b0;
    assign hit2 = 1'b0;
`endif

    always_comb begin
        rdata1 = '0;
        if (rst && re1 && raddr1 != '0) begin
            rdata1 = hit1 ? wdata : regs[raddr1];
        end
    end

    always_comb begin
        rdata2 = '0;
        if (rst && re2 && raddr2 != '0) begin
            rdata2 = hit2 ? wdata : regs[raddr2];
        end
    end

    assign busy1 = rst && re1 && raddr1 != '0 && busy[raddr1] && !hit1;
    assign busy2 = rst && re2 && raddr2 != '0 && busy[raddr2] && !hit2;

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed self-checking bench for regfile_sb.
// Works for both the default build and the REGFILE_BYPASS_EN build.
module tb_regfile_sb;

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        re1;
    logic [4:0]  raddr1;
    logic [31:0] rdata1;
    logic        re2;
    logic [4:0]  raddr2;
    logic [31:0] rdata2;
    logic        iss_we;
    logic [4:0]  iss_addr;
    logic        busy1;
    logic        busy2;

    int n_chk;
    int n_fail;

    regfile_sb dut (
        .clk     (clk),
        .rst     (rst),
        .we      (we),
        .waddr   (waddr),
        .wdata   (wdata),
        .re1     (re1),
        .raddr1  (raddr1),
        .rdata1  (rdata1),
        .re2     (re2),
        .raddr2  (raddr2),
        .rdata2  (rdata2),
        .iss_we  (iss_we),
        .iss_addr(iss_addr),
        .busy1   (busy1),
        .busy2   (busy2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        rst = 1'b0;
        we = 1'b0; waddr = '0; wdata = '0;
        re1 = 1'b1; raddr1 = 5'd5;
        re2 = 1'b1; raddr2 = 5'd5;
        iss_we = 1'b0; iss_addr = '0;
        #2;
        chk("rst_rdata1", rdata1, 32'h0);
        chk("rst_busy1", {31'b0, busy1}, 32'h0);
        @(negedge clk);
        rst = 1'b1;

        // write r5 and issue r5 on the same edge
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEADBEEF;
        iss_we = 1'b1; iss_addr = 5'd5;
        step();
        we = 1'b0; iss_we = 1'b0;
        #1;
        chk("r5_rdata1", rdata1, 32'hDEADBEEF);
        chk("r5_busy1", {31'b0, busy1}, 32'h1);
        rst = 1'b0;
        #1;
        chk("midrst_rdata1", rdata1, 32'h0);
        chk("midrst_busy1", {31'b0, busy1}, 32'h0);
        rst = 1'b1;
        #1;
        chk("postrst_r5", rdata1, 32'h0);
        chk("postrst_busy1", {31'b0, busy1}, 32'h0);

        // zero register
        @(negedge clk);
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFFFFFF;
        iss_we = 1'b1; iss_addr = 5'd0;
        raddr1 = 5'd0;
        #1;
        chk("r0_wb_cycle", rdata1, 32'h0);
        step();
        we = 1'b0; iss_we = 1'b0;
        #1;
        chk("r0_rdata1", rdata1, 32'h0);
        chk("r0_busy1", {31'b0, busy1}, 32'h0);

        // write then read on both ports
        we = 1'b1; waddr = 5'd3; wdata = 32'h12345678;
        step();
        we = 1'b0;
        raddr1 = 5'd3; raddr2 = 5'd3;
        #1;
        chk("r3_rdata1", rdata1, 32'h12345678);
        chk("r3_rdata2", rdata2, 32'h12345678);
        re2 = 1'b0;
        #1;
        chk("r3_re2_off", rdata2, 32'h0);
        re2 = 1'b1;

        // r7=1 with a same-edge issue of r7; issue wins
        we = 1'b1; waddr = 5'd7; wdata = 32'h1;
        iss_we = 1'b1; iss_addr = 5'd7;
        step();
        iss_we = 1'b0;
        wdata = 32'hA5A5A5A5;
        raddr1 = 5'd7;
        #1;
`ifdef REGFILE_BYPASS_EN
        chk("byp_rdata1", rdata1, 32'hA5A5A5A5);
        chk("byp_busy1", {31'b0, busy1}, 32'h0);
`else
        chk("nobyp_rdata1", rdata1, 32'h1);
        chk("nobyp_busy1", {31'b0, busy1}, 32'h1);
`endif
        step();
        we = 1'b0;
        #1;
        chk("r7_after_rdata1", rdata1, 32'hA5A5A5A5);
        chk("r7_after_busy1", {31'b0, busy1}, 32'h0);

        // scoreboard on r9
        iss_we = 1'b1; iss_addr = 5'd9;
        step();
        iss_we = 1'b0;
        raddr2 = 5'd9;
        #1;
        chk("r9_busy_set", {31'b0, busy2}, 32'h1);
        step();
        chk("r9_busy_hold", {31'b0, busy2}, 32'h1);
        we = 1'b1; waddr = 5'd9; wdata = 32'h99;
        iss_we = 1'b1; iss_addr = 5'd9;
        step();
        we = 1'b0; iss_we = 1'b0;
        #1;
        chk("r9_set_wins", {31'b0, busy2}, 32'h1);
        chk("r9_rdata2", rdata2, 32'h99);
        we = 1'b1; waddr = 5'd9; wdata = 32'h77;
        step();
        we = 1'b0;
        #1;
        chk("r9_busy_clr", {31'b0, busy2}, 32'h0);
        chk("r9_rdata2_b", rdata2, 32'h77);

        // parallel issue r4 and writeback r6 (r6 previously issued)
        iss_we = 1'b1; iss_addr = 5'd6;
        step();
        iss_addr = 5'd4;
        we = 1'b1; waddr = 5'd6; wdata = 32'h66;
        step();
        we = 1'b0; iss_we = 1'b0;
        raddr1 = 5'd4; raddr2 = 5'd6;
        #1;
        chk("par_busy4", {31'b0, busy1}, 32'h1);
        chk("par_busy6", {31'b0, busy2}, 32'h0);
        chk("par_r6", rdata2, 32'h66);
        re1 = 1'b0;
        #1;
        chk("re1_off_busy", {31'b0, busy1}, 32'h0);
        re1 = 1'b1;

        // write in flight on an edge while reset is low is lost
        @(negedge clk);
        we = 1'b1; waddr = 5'd3; wdata = 32'hBAD0BAD0;
        rst = 1'b0;
        step();
        we = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        raddr1 = 5'd3; raddr2 = 5'd4;
        #1;
        chk("lost_write_r3", rdata1, 32'h0);
        chk("rst_busy4", {31'b0, busy2}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

General-purpose register file with issue scoreboard: the consumer end of the execute-stage result interface (destination address, write enable, write data) and the source of the two operands that decode hands to execute. Holds 32×32-bit registers, services two read ports from decode, and keeps one busy bit per register so decode can stall on an outstanding write. Register 0 is hard-wired to zero.

## Interface
- DATA_W, 32, register width (matches RegBus)
- ADDR_W, 5, register address width (matches RegAddrBus)
- NREG, 32, number of registers (2**ADDR_W)

- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-low
- we  in  1  writeback enable (from pipeline write stage)
- waddr  in  ADDR_W  writeback destination
- wdata  in  DATA_W  writeback data
- re1  in  1  read enable, port 1
- raddr1  in  ADDR_W  read address, port 1
- rdata1  out  DATA_W  read data, port 1 (combinational)
- re2  in  1  read enable, port 2
- raddr2  in  ADDR_W  read address, port 2
- rdata2  out  DATA_W  read data, port 2 (combinational)
- iss_we  in  1  decode issued an instruction that will write iss_addr
- iss_addr  in  ADDR_W  destination of the issued instruction
- busy1  out  1  port-1 operand has an outstanding write
- busy2  out  1  port-2 operand has an outstanding write

## Operation
- Storage: regs[0..NREG-1], busy[0..NREG-1].
- Write: at rising edge, if we=1 and waddr≠0, regs[waddr] ← wdata. Writes to 0 discarded.
- Read (per port n, combinational), priority order:
  - rst=0 → rdatan = 0
  - ren=0 → 0
  - raddrn=0 → 0
  - bypass hit (see Configuration) → wdata
  - else regs[raddrn]
- Both ports may read the same address; results identical.
- Scoreboard, at rising edge, per address a≠0:
  - set if iss_we=1 and iss_addr=a
  - else clear if we=1 and waddr=a
  - set and clear on same address same cycle → set wins (newer issue outstanding)
  - iss_addr=0 never sets; busy[0] constant 0
- busyn = ren & busy[raddrn] & ~(bypass hit on port n); 0 when raddrn=0 or rst=0.
- Decode holds iss_we low while stalling; block does not check this.

## Timing
- Reset (rst falling, asynchronous): all regs and busy bits cleared immediately; rdata1/2=0, busy1/2=0 while rst=0. First write accepted on first rising edge after rst returns high.
- Reset mid-operation: any in-flight write on the edge coinciding with rst=0 is lost; all busy bits cleared.
- Write latency: data visible in regs one edge after we; same-cycle visibility only via bypass.
- Read latency: zero cycles (combinational from raddr/re/regs/we/waddr/wdata).
- Scoreboard latency: busy visible the cycle after iss_we; clears the cycle after matching writeback (same cycle with bypass).
- Simultaneous write and issue to different addresses: both take effect on the same edge.

## Configuration
- REGFILE_BYPASS_EN defined: bypass hit on port n when we=1, waddr=raddrn, raddrn≠0, ren=1; rdatan=wdata and busyn=0 in that cycle.
- Undefined: no bypass; rdatan=regs[raddrn] (old value) in the writeback cycle, busyn stays 1 until the edge clears it; decode stalls one extra cycle.

## Test plan
- Reset: write 0xDEADBEEF to r5, set busy r5, drop rst mid-cycle → rdata1(r5)=0, busy1=0 immediately, before next edge.
- Zero register: we=1 waddr=0 wdata=0xFFFFFFFF, then re1=1 raddr1=0 → rdata1=0; iss_we iss_addr=0 → busy1=0.
- Write/read: write r3=0x12345678 on edge N; cycle N+1 re1=re2=1 raddr=3 → both ports 0x12345678; re2=0 → rdata2=0.
- Bypass: r7=0x1, same cycle we=1 waddr=7 wdata=0xA5A5A5A5 and raddr1=7 → with REGFILE_BYPASS_EN rdata1=0xA5A5A5A5, busy1=0; without, rdata1=0x1, then 0xA5A5A5A5 after edge.
- Scoreboard: iss_we r9 on edge N → busy2(r9)=1 at N+1; writeback r9 on edge M → busy2=0 after M; same-edge issue+writeback r9 → busy2 stays 1.
- Parallel: issue r4 and writeback r6 same edge → busy[4]=1, busy[6]=0, regs[6] updated.
